seg_bcd_counter: RTL and testbench

//   Parametrised N-digit decimal counter with built-in prescaler and 7-segment encoders.

---
 rtl/seg_bcd_counter.sv | 151 +++++++++++++++
 tb/tb_seg_bcd_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_counter.sv
// N-digit BCD up/down counter with prescaler, clear/load, wrap pulse and 7-segment outputs.
// Optional leading-zero blanking on the segment outputs when SEG_LZB_EN is defined.
module seg_bcd_counter #(
  parameter int DIGITS  = 3,
  parameter int DIV_CNT = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  wrap,
  output logic [8*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = 8 * DIGITS;
  localparam int PW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV_CNT - 1);

  function automatic logic [7:0] enc7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [SW-1:0] seg_encode(input logic [BW-1:0] b);
    logic [SW-1:0] s;
`ifdef SEG_LZB_EN
    logic hi_zero;
    hi_zero = 1'b1;
`endif
    s = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      s[8*k +: 8] = enc7(b[4*k +: 4]);
`ifdef SEG_LZB_EN
      // Blank a digit only while everything from it upward is zero.
      hi_zero = hi_zero && (b[4*k +: 4] == 4'd0);
      if (k > 0 && hi_zero) s[8*k +: 8] = 8'hFF;
`endif
    end
    return s;
  endfunction

  function automatic logic [BW-1:0] clamp_bcd(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Returns {carry_out, next}; carry/borrow out of the top digit is the wrap.
  function automatic logic [BW:0] step_bcd(input logic [BW-1:0] v, input logic dir_up);
    logic [BW-1:0] n;
    logic          c;
    n = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (dir_up) begin
          if (v[4*k +: 4] == 4'd9) n[4*k +: 4] = 4'd0;
          else begin
            n[4*k +: 4] = v[4*k +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*k +: 4] == 4'd0) n[4*k +: 4] = 4'd9;
          else begin
            n[4*k +: 4] = v[4*k +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, n};
  endfunction

  localparam logic [SW-1:0] SEG_RST = seg_encode({BW{1'b0}});

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [BW:0]   stepped;

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    stepped = step_bcd(bcd_q, up);
    seg_d   = seg_encode(bcd_q);
    if (clr) begin
      bcd_d   = '0;
      presc_d = '0;
    end else if (load) begin
      bcd_d   = clamp_bcd(load_val);
      presc_d = '0;
    end else if (en) begin
      if (presc_q == PMAX) begin
        presc_d = '0;
        bcd_d   = stepped[BW-1:0];
        tick_d  = 1'b1;
        wrap_d  = stepped[BW];
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_RST;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd  = bcd_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_seg_bcd_counter.sv
// Scoreboard bench for seg_bcd_counter (DIGITS=3, DIV_CNT=4) plus a DIV_CNT=1 instance.
module tb_seg_bcd_counter;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en, up, clr, load;
  logic [11:0] load_val;
  logic [11:0] bcd;
  logic        tick, wrap;
  logic [23:0] seg;

  logic        en1, up1, clr1, load1;
  logic [11:0] load_val1;
  logic [11:0] bcd1;
  logic        tick1, wrap1;
  logic [23:0] seg1;

  typedef struct {
    logic [11:0] bcd;
    logic        wrap;
    logic [23:0] seg;
  } exp_t;

  exp_t        q[$];
  int          ncmp = 0;
  int          nfail = 0;
  logic        seg_pend = 1'b0;
  logic [23:0] seg_want;

  seg_bcd_counter #(.DIGITS(3), .DIV_CNT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .bcd(bcd), .tick(tick), .wrap(wrap), .seg(seg)
  );

  seg_bcd_counter #(.DIGITS(3), .DIV_CNT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .up(up1), .clr(clr1), .load(load1),
    .load_val(load_val1), .bcd(bcd1), .tick(tick1), .wrap(wrap1), .seg(seg1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every tick pops one expected step; segments are checked one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (seg_pend) begin
      check("seg_after_tick", seg, seg_want);
      seg_pend = 1'b0;
    end
    if (tick === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("tick_bcd", bcd, e.bcd);
        check("tick_wrap", wrap, e.wrap);
        seg_want = e.seg;
        seg_pend = 1'b1;
      end
    end
  end

  logic [11:0] up_tbl [12] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006,
                               12'h007, 12'h008, 12'h009, 12'h010, 12'h011, 12'h012};

  initial begin
    rst = 1'b1; en = 0; up = 1; clr = 0; load = 0; load_val = '0;
    en1 = 0; up1 = 1; clr1 = 0; load1 = 0; load_val1 = '0;
    @(negedge clk);
    check("rst_bcd", bcd, 12'h000);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
    check("rst_seg", seg, LZB ? 24'hFFFFC0 : 24'hC0C0C0);
    rst = 1'b0;

    // Count up: first step after the 4th enabled edge, second after the 8th.
    en = 1; up = 1;
    q.push_back('{12'h001, 1'b0, LZB ? 24'hFFFFF9 : 24'hC0C0F9});
    q.push_back('{12'h002, 1'b0, LZB ? 24'hFFFFA4 : 24'hC0C0A4});
    run(3);
    check("no_step_3rd_edge", bcd, 12'h000);
    check("no_tick_3rd_edge", tick, 0);
    run(5);
    en = 0;
    run(1);

    // Load 999 then wrap up to 000; then clamped load 9F9.
    load_val = 12'h999; load = 1; run(1); load = 0;
    check("load_999", bcd, 12'h999);
    check("load_no_tick", tick, 0);
    en = 1;
    q.push_back('{12'h000, 1'b1, LZB ? 24'hFFFFC0 : 24'hC0C0C0});
    run(4);
    en = 0;
    load_val = 12'h9F9; load = 1; run(1); load = 0;
    check("load_clamp", bcd, 12'h999);
    run(1);
    check("seg_999", seg, 24'h909090);

    // Count down: 000 -> 999 wraps, 100 -> 099 does not; en low delays the step.
    clr = 1; run(1); clr = 0;
    check("clr_bcd", bcd, 12'h000);
    up = 0; en = 1;
    q.push_back('{12'h999, 1'b1, 24'h909090});
    run(4);
    en = 0;
    load_val = 12'h100; load = 1; run(1); load = 0;
    en = 1;
    q.push_back('{12'h099, 1'b0, LZB ? 24'hFF9090 : 24'hC09090});
    run(2);
    en = 0; run(2);
    check("en_low_hold", bcd, 12'h100);
    en = 1; run(1);
    check("en_low_delay", bcd, 12'h100);
    run(1);

    // clr and load on the same edge: clr wins and prescaler restarts.
    up = 1; run(2);
    clr = 1; load = 1; load_val = 12'h555; run(1); clr = 0; load = 0;
    check("clr_over_load", bcd, 12'h000);
    q.push_back('{12'h001, 1'b0, LZB ? 24'hFFFFF9 : 24'hC0C0F9});
    run(3);
    check("presc_cleared", bcd, 12'h000);
    run(1);
    run(2);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("arst_bcd", bcd, 12'h000);
    check("arst_tick", tick, 0);
    check("arst_wrap", wrap, 0);
    check("arst_seg", seg, LZB ? 24'hFFFFC0 : 24'hC0C0C0);
    @(negedge clk);
    rst = 1'b0; en = 0;

    // Segment encoding / blanking.
    load_val = 12'h007; load = 1; run(1); load = 0; run(1);
    check("seg_007", seg, LZB ? 24'hFFFFF8 : 24'hC0C0F8);
    load_val = 12'h100; load = 1; run(1); load = 0; run(1);
    check("seg_100", seg, 24'hF9C0C0);

    // DIV_CNT=1 instance steps on every enabled edge.
    en1 = 1; up1 = 1;
    for (int i = 0; i < 12; i++) begin
      run(1);
      check("div1_bcd", bcd1, up_tbl[i]);
      check("div1_tick", tick1, 1);
    end
    en1 = 0; run(1);
    check("div1_seg_012", seg1, LZB ? 24'hFFF9A4 : 24'hC0F9A4);
    load_val1 = 12'h998; load1 = 1; run(1); load1 = 0;
    en1 = 1; run(1);
    check("div1_999", bcd1, 12'h999);
    check("div1_nowrap", wrap1, 0);
    run(1);
    check("div1_wrap_bcd", bcd1, 12'h000);
    check("div1_wrap", wrap1, 1);
    en1 = 0;

    run(2);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
